// File: rtl/parity_mem_if.sv
// parity_mem_if: request/response bundle between a host and the parity-protected RAM
interface parity_mem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              inject_err;
    logic              err_clr;
    logic [DATA_W:0]   data_out;
    logic              rd_valid;
    logic              parity_err;
    logic              unwritten;
    logic              sticky_err;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output write, read, address, data_in, inject_err, err_clr,
        input  data_out, rd_valid, parity_err, unwritten, sticky_err, err_count
    );

    modport slave (
        input  write, read, address, data_in, inject_err, err_clr,
        output data_out, rd_valid, parity_err, unwritten, sticky_err, err_count
    );
endinterface

// File: rtl/parity_mem.sv
// parity_mem: parity-protected single-port RAM with written bitmap and saturating error counter
module parity_mem #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 8
) (
    input logic         clk,
    input logic         rst,
    parity_mem_if.slave bus
);
    localparam int   DEPTH = 2 ** ADDR_W;
    localparam logic ODD   = (ODD_PARITY != 0);

    logic [DATA_W:0]    mem [DEPTH];
    logic [DEPTH-1:0]   written_q, written_d;
    logic [DATA_W:0]    data_out_q, data_out_d;
    logic               rd_valid_q;
    logic               parity_err_q, parity_err_d;
    logic               unwritten_q, unwritten_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W:0]    rd_word;
    logic               hit, wr_p, rd_p, rd_err, err_ev;

    // read-before-write: everything here sees the array and bitmap as they were before the edge
    always_comb begin
        rd_word      = mem[bus.address];
        hit          = written_q[bus.address];
        wr_p         = ^bus.data_in ^ ODD ^ bus.inject_err;
        rd_p         = ^rd_word[DATA_W-1:0] ^ ODD;
        rd_err       = hit & (rd_word[DATA_W] != rd_p);
        err_ev       = bus.read & rd_err;
        data_out_d   = bus.read ? (hit ? rd_word : '0) : data_out_q;
        parity_err_d = bus.read ? rd_err : parity_err_q;
        unwritten_d  = bus.read ? ~hit : unwritten_q;
        written_d    = bus.write ? (written_q | (DEPTH'(1) << bus.address)) : written_q;
        sticky_d     = bus.err_clr ? 1'b0 : (sticky_q | err_ev);
        cnt_d        = bus.err_clr ? '0 : ((err_ev && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q);
    end

    // storage array is intentionally not reset; writes during reset are dropped
    always_ff @(posedge clk) begin
        if (!rst && bus.write) mem[bus.address] <= {wr_p, bus.data_in};
    end

    // output, bitmap and error-accounting registers
    always_ff @(posedge clk) begin
        if (rst) begin
            written_q    <= '0;
            data_out_q   <= '0;
            rd_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            unwritten_q  <= 1'b0;
            sticky_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            written_q    <= written_d;
            data_out_q   <= data_out_d;
            rd_valid_q   <= bus.read;
            parity_err_q <= parity_err_d;
            unwritten_q  <= unwritten_d;
            sticky_q     <= sticky_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.unwritten  = unwritten_q;
    assign bus.sticky_err = sticky_q;
    assign bus.err_count  = cnt_q;
endmodule
